// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache line refill path.
// Holds the line geometry (line, beat and address widths, memory depth),
// the quantities derived from it, the refill FSM state encoding and the
// helper that clears the byte-within-line bits of an address.
package icache_pkg;

    localparam int LINE_WIDTH   = 512;
    localparam int BEAT_WIDTH   = 32;
    localparam int MEMORY_DEPTH = 512;
    localparam int ADDR_WIDTH   = 32;

    // Byte-offset bits inside a line, line-index bits, beats per line.
    localparam int OFF_W      = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W      = $clog2(MEMORY_DEPTH);
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEATS);
    // Byte-offset bits inside one beat; the critical-word index sits above them.
    localparam int WORD_OFF_W = $clog2(BEAT_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FILL  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Clear the byte-within-line bits so the request is line aligned.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] mask;
        mask = {ADDR_WIDTH{1'b1}} << OFF_W;
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Beat collector for one cache line.
// Keeps the beat counter and the line buffer, flags the last beat of the
// line, and produces the one-cycle forward pulse for the critical word.
// Ports:
//   CLK, RST_N    clock and asynchronous active-low reset
//   start         clears the beat counter when a new refill is accepted
//   crit          index of the beat holding the requested instruction
//   beat_accept   a beat is being accepted this cycle
//   beat_data     the beat being accepted
//   last_beat     the accepted beat is the final one of the line
//   line          assembled line buffer
//   fwd_valid     one-cycle pulse, the cycle after the critical beat
//   fwd_data      the critical beat, held until the next one
module icache_line_assembler
    import icache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [CNT_W-1:0]      crit,
    input  logic                  beat_accept,
    input  logic [BEAT_WIDTH-1:0] beat_data,
    output logic                  last_beat,
    output logic [LINE_WIDTH-1:0] line,
    output logic                  fwd_valid,
    output logic [BEAT_WIDTH-1:0] fwd_data
);

    logic [CNT_W-1:0]      cnt_r;
    logic [LINE_WIDTH-1:0] line_r;
    logic                  fwd_valid_r;
    logic [BEAT_WIDTH-1:0] fwd_data_r;
    logic                  crit_hit_s;
    logic                  last_beat_s;

    // Decode last-beat and critical-beat hits from the current counter.
    always_comb begin
        last_beat_s = 1'b0;
        crit_hit_s  = 1'b0;
        if (beat_accept) begin
            last_beat_s = (cnt_r == CNT_W'(BEATS - 1));
            crit_hit_s  = (cnt_r == crit);
        end else begin
            last_beat_s = 1'b0;
            crit_hit_s  = 1'b0;
        end
    end

    // Beat counter and line buffer; the counter wraps to 0 after the last beat.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r  <= {CNT_W{1'b0}};
            line_r <= {LINE_WIDTH{1'b0}};
        end else if (start) begin
            cnt_r  <= {CNT_W{1'b0}};
        end else if (beat_accept) begin
            line_r[cnt_r * BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
            cnt_r                                    <= cnt_r + CNT_W'(1);
        end
    end

    // Critical-word forward register: pulse one cycle after the hit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fwd_valid_r <= 1'b0;
            fwd_data_r  <= {BEAT_WIDTH{1'b0}};
        end else begin
            fwd_valid_r <= crit_hit_s;
            if (crit_hit_s) begin
                fwd_data_r <= beat_data;
            end
        end
    end

    assign last_beat = last_beat_s;
    assign line      = line_r;
    assign fwd_valid = fwd_valid_r;
    assign fwd_data  = fwd_data_r;

endmodule

// File: rtl/icache_line_refill_writer.sv
// Write-side driver of the instruction-cache line memory.
// On a miss it requests the line-aligned address from the next level,
// gathers the returned beats into a full line (icache_line_assembler),
// forwards the critical word as soon as it arrives, writes the line through
// the single write port and then pulses REFILL_DONE one cycle later, so a
// re-read issued on DONE observes the new line despite the registered read.
// Ports:
//   CLK, RST_N                        clock, asynchronous active-low reset
//   REFILL_REQ, REFILL_ADDR           miss pulse and byte address (sampled in IDLE)
//   REFILL_BUSY                       high whenever not IDLE
//   MEM_ADDR, MEM_ADDR_VALID/READY    line-aligned request handshake
//   MEM_DATA, MEM_DATA_VALID/READY    returned beats, ascending word order
//   FWD_DATA, FWD_VALID               critical word forward
//   WRITE_ADDRESS, DATA_IN,
//   WRITE_ENABLE                      line memory write port
//   REFILL_DONE                       completion pulse after the write
// All outputs are registered; they are loaded from the next-state decode so
// they line up with the state register.
module icache_line_refill_writer
    import icache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REFILL_REQ,
    input  logic [ADDR_WIDTH-1:0] REFILL_ADDR,
    output logic                  REFILL_BUSY,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_ADDR_VALID,
    input  logic                  MEM_ADDR_READY,
    input  logic [BEAT_WIDTH-1:0] MEM_DATA,
    input  logic                  MEM_DATA_VALID,
    output logic                  MEM_DATA_READY,
    output logic [BEAT_WIDTH-1:0] FWD_DATA,
    output logic                  FWD_VALID,
    output logic [IDX_W-1:0]      WRITE_ADDRESS,
    output logic [LINE_WIDTH-1:0] DATA_IN,
    output logic                  WRITE_ENABLE,
    output logic                  REFILL_DONE
);

    state_t                state_r;
    state_t                state_next_s;
    logic                  start_s;
    logic                  beat_accept_s;
    logic                  last_beat_s;

    logic [CNT_W-1:0]      crit_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [IDX_W-1:0]      write_address_r;
    logic                  refill_busy_r;
    logic                  mem_addr_valid_r;
    logic                  mem_data_ready_r;
    logic                  write_enable_r;
    logic                  refill_done_r;

    // Beats are only taken while the FSM is filling.
    assign beat_accept_s = (state_r == FILL) && MEM_DATA_VALID;

    icache_line_assembler u_assembler (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start_s),
        .crit        (crit_r),
        .beat_accept (beat_accept_s),
        .beat_data   (MEM_DATA),
        .last_beat   (last_beat_s),
        .line        (DATA_IN),
        .fwd_valid   (FWD_VALID),
        .fwd_data    (FWD_DATA)
    );

    // Next-state decode; a new request is only taken in IDLE.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (REFILL_REQ) begin
                    state_next_s = REQ;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (MEM_ADDR_READY) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = REQ;
                end
            end
            FILL: begin
                if (last_beat_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = FILL;
                end
            end
            WRITE:   state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture: address, line index and critical beat held for the whole refill.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_addr_r      <= {ADDR_WIDTH{1'b0}};
            write_address_r <= {IDX_W{1'b0}};
            crit_r          <= {CNT_W{1'b0}};
        end else if (start_s) begin
            mem_addr_r      <= line_align(REFILL_ADDR);
            write_address_r <= REFILL_ADDR[OFF_W +: IDX_W];
            crit_r          <= REFILL_ADDR[OFF_W-1:WORD_OFF_W];
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            refill_busy_r    <= 1'b0;
            mem_addr_valid_r <= 1'b0;
            mem_data_ready_r <= 1'b0;
            write_enable_r   <= 1'b0;
            refill_done_r    <= 1'b0;
        end else begin
            refill_busy_r    <= (state_next_s != IDLE);
            mem_addr_valid_r <= (state_next_s == REQ);
            mem_data_ready_r <= (state_next_s == FILL);
            write_enable_r   <= (state_next_s == WRITE);
            refill_done_r    <= (state_next_s == DONE);
        end
    end

    assign REFILL_BUSY    = refill_busy_r;
    assign MEM_ADDR       = mem_addr_r;
    assign MEM_ADDR_VALID = mem_addr_valid_r;
    assign MEM_DATA_READY = mem_data_ready_r;
    assign WRITE_ADDRESS  = write_address_r;
    assign WRITE_ENABLE   = write_enable_r;
    assign REFILL_DONE    = refill_done_r;

endmodule

// File: tb/tb_icache_line_refill_writer.sv
// Scoreboard bench for icache_line_refill_writer. The stimulus process issues
// refills and pushes what it expects (request address, forwarded word and its
// cycle, written line/index and its cycle); a monitor pops and compares when the
// DUT shows a request, forward pulse, write strobe or done pulse. A small line
// memory with registered read sits on the write port for the re-read on DONE.
module tb_icache_line_refill_writer;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         REFILL_REQ = 1'b0;
    logic [31:0]  REFILL_ADDR = 32'h0;
    logic         REFILL_BUSY;
    logic [31:0]  MEM_ADDR;
    logic         MEM_ADDR_VALID;
    logic         MEM_ADDR_READY = 1'b0;
    logic [31:0]  MEM_DATA = 32'h0;
    logic         MEM_DATA_VALID = 1'b0;
    logic         MEM_DATA_READY;
    logic [31:0]  FWD_DATA;
    logic         FWD_VALID;
    logic [8:0]   WRITE_ADDRESS;
    logic [511:0] DATA_IN;
    logic         WRITE_ENABLE;
    logic         REFILL_DONE;

    icache_line_refill_writer dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .REFILL_REQ     (REFILL_REQ),
        .REFILL_ADDR    (REFILL_ADDR),
        .REFILL_BUSY    (REFILL_BUSY),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_ADDR_VALID (MEM_ADDR_VALID),
        .MEM_ADDR_READY (MEM_ADDR_READY),
        .MEM_DATA       (MEM_DATA),
        .MEM_DATA_VALID (MEM_DATA_VALID),
        .MEM_DATA_READY (MEM_DATA_READY),
        .FWD_DATA       (FWD_DATA),
        .FWD_VALID      (FWD_VALID),
        .WRITE_ADDRESS  (WRITE_ADDRESS),
        .DATA_IN        (DATA_IN),
        .WRITE_ENABLE   (WRITE_ENABLE),
        .REFILL_DONE    (REFILL_DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard queues.
    logic [31:0]  exp_req_q[$];
    logic [31:0]  exp_fwd_q[$];
    int           exp_fwd_cyc_q[$];
    logic [511:0] exp_line_q[$];
    logic [8:0]   exp_idx_q[$];
    int           exp_we_cyc_q[$];

    int           last_we_cyc = -100;
    int           last_req_cyc = 0;
    logic [511:0] last_line = '0;
    logic         prev_addr_valid = 1'b0;
    logic         rd_pending = 1'b0;

    // Line memory behind the write port: registered read, read issued on DONE.
    logic [511:0] mem_model [0:511];
    logic [511:0] rd_data = '0;
    always @(posedge CLK) begin
        if (WRITE_ENABLE) mem_model[WRITE_ADDRESS] <= DATA_IN;
        if (REFILL_DONE)  rd_data <= mem_model[WRITE_ADDRESS];
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT events against the scoreboard away from the active edge.
    always @(negedge CLK) begin
        if (MEM_ADDR_VALID) begin
            chk("req_pending", 512'(exp_req_q.size()), 512'd1);
            if (exp_req_q.size() > 0) chk("mem_addr", MEM_ADDR, exp_req_q[0]);
        end
        if (prev_addr_valid && !MEM_ADDR_VALID && exp_req_q.size() > 0) void'(exp_req_q.pop_front());
        prev_addr_valid <= MEM_ADDR_VALID;

        if (FWD_VALID) begin
            chk("fwd_pending", 512'(exp_fwd_q.size()), 512'd1);
            if (exp_fwd_q.size() > 0) begin
                chk("fwd_data", FWD_DATA, exp_fwd_q[0]);
                chk("fwd_cycle", 512'(cyc), 512'(exp_fwd_cyc_q[0]));
                void'(exp_fwd_q.pop_front());
                void'(exp_fwd_cyc_q.pop_front());
            end
        end

        if (WRITE_ENABLE) begin
            chk("we_pending", 512'(exp_line_q.size()), 512'd1);
            if (exp_line_q.size() > 0) begin
                chk("data_in", DATA_IN, exp_line_q[0]);
                chk("write_address", WRITE_ADDRESS, exp_idx_q[0]);
                chk("we_cycle", 512'(cyc), 512'(exp_we_cyc_q[0]));
                last_line <= exp_line_q[0];
                void'(exp_line_q.pop_front());
                void'(exp_idx_q.pop_front());
                void'(exp_we_cyc_q.pop_front());
            end
            last_we_cyc <= cyc;
        end

        if (REFILL_DONE) chk("done_after_we", 512'(cyc), 512'(last_we_cyc + 1));
        if (rd_pending) chk("reread_new_line", rd_data, last_line);
        rd_pending <= REFILL_DONE;

        if (MEM_ADDR_VALID || MEM_DATA_READY || WRITE_ENABLE || REFILL_DONE)
            chk("busy_when_active", REFILL_BUSY, 1'b1);
    end

    // One refill. gap_mode: 0 back-to-back, 1 gap before every odd beat, 2 random gaps.
    task automatic do_refill(input logic [31:0] addr, input int ready_delay, input int gap_mode,
                             input int abort_after, input bit stray, input bit junk, input bit seq_pat);
        logic [31:0]  w [16];
        logic [511:0] line;
        int           crit;
        logic [8:0]   idx;
        bit           got;
        int           ngap;
        for (int k = 0; k < 16; k++) begin
            w[k] = seq_pat ? (32'hA0 + 32'(k)) : $urandom;
            line[k*32 +: 32] = w[k];
        end
        crit = int'((addr % 64) / 4);
        idx  = 9'((addr / 64) % 512);

        @(negedge CLK);
        REFILL_REQ = 1'b1;
        REFILL_ADDR = addr;
        last_req_cyc = cyc;
        exp_req_q.push_back(addr - (addr % 64));
        @(negedge CLK);
        REFILL_REQ = 1'b0;
        REFILL_ADDR = $urandom;
        if (junk) begin
            MEM_DATA_VALID = 1'b1;
            MEM_DATA = 32'hDEAD_BEEF;
        end

        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (n >= ready_delay) MEM_ADDR_READY = 1'b1;
            if (MEM_ADDR_VALID && MEM_ADDR_READY) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("addr_handshake", got, 1'b1);
        if (!got) return;
        @(negedge CLK);
        MEM_ADDR_READY = 1'($urandom_range(0, 1));

        for (int k = 0; k < 16; k++) begin
            if (k == abort_after) begin
                RST_N = 1'b0;
                MEM_DATA_VALID = 1'b0;
                #1;
                chk("reset_outputs_zero",
                    512'({REFILL_BUSY, MEM_ADDR, MEM_ADDR_VALID, MEM_DATA_READY, FWD_DATA, FWD_VALID,
                          WRITE_ADDRESS, WRITE_ENABLE, REFILL_DONE} != '0 || DATA_IN != '0), 512'd0);
                repeat (2) @(negedge CLK);
                RST_N = 1'b1;
                return;
            end
            ngap = (gap_mode == 1) ? (k % 2) : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (ngap) begin
                MEM_DATA_VALID = 1'b0;
                MEM_DATA = $urandom;
                @(negedge CLK);
                REFILL_REQ = 1'b0;
            end
            MEM_DATA_VALID = 1'b1;
            MEM_DATA = w[k];
            got = 1'b0;
            for (int j = 0; j < 40; j++) begin
                if (MEM_DATA_READY) begin
                    got = 1'b1;
                    break;
                end
                @(negedge CLK);
            end
            chk("beat_ready", got, 1'b1);
            if (!got) begin
                MEM_DATA_VALID = 1'b0;
                return;
            end
            if (k == crit) begin
                exp_fwd_q.push_back(w[k]);
                exp_fwd_cyc_q.push_back(cyc + 1);
            end
            if (k == 15) begin
                exp_line_q.push_back(line);
                exp_idx_q.push_back(idx);
                exp_we_cyc_q.push_back(cyc + 1);
            end
            if (stray && k == 8) begin
                REFILL_REQ = 1'b1;
                REFILL_ADDR = $urandom;
            end
            @(negedge CLK);
            REFILL_REQ = 1'b0;
        end
        MEM_DATA_VALID = 1'b0;

        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (REFILL_DONE) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("done_seen", got, 1'b1);
        @(negedge CLK);
        chk("idle_after_done",
            512'({REFILL_BUSY, MEM_ADDR_VALID, MEM_DATA_READY, WRITE_ENABLE, REFILL_DONE}), 512'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset_state",
            512'({REFILL_BUSY, MEM_ADDR, MEM_ADDR_VALID, MEM_DATA_READY, FWD_DATA, FWD_VALID,
                  WRITE_ADDRESS, WRITE_ENABLE, REFILL_DONE} != '0 || DATA_IN != '0), 512'd0);
        RST_N = 1'b1;

        // Best case, critical word 1, words A0..AF.
        do_refill(32'h0000_1044, 0, 0, -1, 1'b0, 1'b0, 1'b1);
        chk("best_case_latency", 512'(last_we_cyc - last_req_cyc), 512'd18);
        // Slow request acceptance, gaps every other beat, junk beat during REQ.
        do_refill(32'h0000_1044, 5, 1, -1, 1'b0, 1'b1, 1'b1);
        // Critical word last, index 0.
        do_refill(32'h0000_003C, 0, 0, -1, 1'b0, 1'b0, 1'b0);
        // Critical word first.
        do_refill(32'h0000_2000, 1, 2, -1, 1'b0, 1'b0, 1'b0);
        // Extra miss pulse during FILL must be ignored.
        do_refill(32'h0001_2388, 2, 2, -1, 1'b1, 1'b0, 1'b0);
        // Reset after 7 beats, then a clean refill.
        do_refill(32'h0000_1044, 0, 0, 7, 1'b0, 1'b0, 1'b1);
        do_refill(32'h0000_1044, 1, 2, -1, 1'b0, 1'b0, 1'b0);
        // High address bits dropped from the index but kept in MEM_ADDR.
        do_refill(32'h8000_1044, 0, 0, -1, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 12; r++) begin
            do_refill($urandom, int'($urandom_range(0, 4)), 2, -1,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (4) @(negedge CLK);
        chk("req_queue_drained", 512'(exp_req_q.size()), 512'd0);
        chk("fwd_queue_drained", 512'(exp_fwd_q.size()), 512'd0);
        chk("write_queue_drained", 512'(exp_line_q.size()), 512'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
